uart_rx_frame: RTL and testbench

Oversampling UART receiver that turns the asynchronous serial line into parallel bytes for the APB-wrapped UART. It synchronises the `rx` pin and detects the start bit. Each bit is sampled at mid-bit, shifted in LSB-first and the stop bit is checked. Completed bytes are presented to the register interface as a one-cycle `rx_valid` pulse with error flags. It is the receive counterpart of the transmit serialiser and uses the same baud-tick generator.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_frame_if.sv | 26 ++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx_frame.sv | 146 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types and default frame constants
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - receiver line/result bundle (parity_err present with UART_RX_PARITY_EN)
interface uart_rx_frame_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);

    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output baud_tick, rx,
                    input  rx_data, rx_valid, frame_err, parity_err, busy);
    modport slave  (input  baud_tick, rx,
                    output rx_data, rx_valid, frame_err, parity_err, busy);
`else
    modport master (output baud_tick, rx,
                    input  rx_data, rx_valid, frame_err, busy);
    modport slave  (input  baud_tick, rx,
                    output rx_data, rx_valid, frame_err, busy);
`endif

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two flops in series; only r_sync is safe to use downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling UART receive framer; even parity stage with UART_RX_PARITY_EN
module uart_rx_frame import uart_pkg::*; #(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_frame_if.slave bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state,  w_state_nx;
    logic [TW-1:0]        r_tick,   w_tick_nx;
    logic [BW-1:0]        r_bit,    w_bit_nx;
    logic [DATA_BITS-1:0] r_sh,     w_sh_nx;
    logic [DATA_BITS-1:0] r_data,   w_data_nx;
    logic                 r_valid,  w_valid_nx;
    logic                 r_ferr,   w_ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad, w_par_bad_nx;
    logic                 r_perr,    w_perr_nx;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.rx),
        .o_q   (w_rx_s)
    );

    // State, counters, shift register and registered result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_tick    <= w_tick_nx;
            r_bit     <= w_bit_nx;
            r_sh      <= w_sh_nx;
            r_data    <= w_data_nx;
            r_valid   <= w_valid_nx;
            r_ferr    <= w_ferr_nx;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nx;
            r_perr    <= w_perr_nx;
`endif
        end
    end

    // Next-state and sampling decisions; everything holds between baud ticks
    always_comb begin
        w_state_nx   = r_state;
        w_tick_nx    = r_tick;
        w_bit_nx     = r_bit;
        w_sh_nx      = r_sh;
        w_data_nx    = r_data;
        w_valid_nx   = 1'b0;
        w_ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nx = r_par_bad;
        w_perr_nx    = 1'b0;
`endif
        if (bus.baud_tick) begin
            w_tick_nx = r_tick + TW'(1);
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) w_state_nx = START;
                end
                START: begin
                    if (r_tick == HALF_LAST) w_state_nx = w_rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (r_tick == FULL_LAST) begin
                        w_sh_nx   = {w_rx_s, r_sh[DATA_BITS-1:1]};
                        w_tick_nx = '0;
                        w_bit_nx  = r_bit + BW'(1);
                        if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nx = PARITY;
`else
                            w_state_nx = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_tick == FULL_LAST) begin
                        w_par_bad_nx = w_rx_s ^ (^r_sh);
                        w_state_nx   = STOP;
                    end
                end
`endif
                STOP: begin
                    if (r_tick == FULL_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_perr_nx = r_par_bad;
`endif
                        if (w_rx_s) begin
                            w_data_nx  = r_sh;
                            w_valid_nx = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_ferr_nx  = 1'b1;
                            w_state_nx = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_rx_s) w_state_nx = IDLE;
                end
                default: w_state_nx = IDLE;
            endcase
            // Both counters restart from zero whenever the state changes
            if (w_state_nx != r_state) begin
                w_tick_nx = '0;
                w_bit_nx  = '0;
            end
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized frame bench for uart_rx_frame (8E1 when UART_RX_PARITY_EN)
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int DB = 8;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS    = 1 + DB + PB + 1;
    // ticks from the tick before the start edge to the stop-bit sample tick
    localparam int STOP_OFS = 1 + OS / 2 + OS * (NBITS - 1);

    typedef struct {
        logic          v;
        logic          fe;
        logic          pe;
        logic [DB-1:0] data;
        int            tick;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_frame_if #(.DATA_BITS(DB)) bus ();

    uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            n_total   = 0;
    int            n_bad     = 0;
    int            g_tick    = 0;
    exp_t          exp_q[$];
    logic [DB-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // baud ticks with random spacing of 3..6 clocks
    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat ($urandom_range(2, 5)) @(negedge clk);
            bus.baud_tick = 1'b1;
            @(negedge clk);
            bus.baud_tick = 1'b0;
        end
    end

    always @(posedge clk) if (bus.baud_tick) g_tick <= g_tick + 1;

    // every pulse cycle must match the next expected frame outcome
    always @(negedge clk) begin
        logic pe;
        exp_t e;
        pe = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe = bus.parity_err;
`endif
        if (bus.rx_valid || bus.frame_err || pe) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_tick", g_tick, e.tick);
                chk("rx_valid", bus.rx_valid, e.v);
                chk("frame_err", bus.frame_err, e.fe);
                chk("parity_err", pe, e.pe);
                chk("rx_data", bus.rx_data, e.data);
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!bus.baud_tick);
        end
        #1;
    endtask

    // must be called just after a tick edge; records the expected outcome then drives the frame
    task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
        exp_t e;
        e.tick = g_tick + STOP_OFS;
        e.v    = stop;
        e.fe   = !stop;
        e.pe   = (PB != 0) && (par != (^d));
        e.data = stop ? d : last_data;
        if (stop) last_data = d;
        exp_q.push_back(e);
        for (int i = 0; i < NBITS; i++) begin
            if (i == 0)                     bus.rx = 1'b0;
            else if (i <= DB)               bus.rx = d[i-1];
            else if (PB != 0 && i == DB + 1) bus.rx = par;
            else                            bus.rx = stop;
            wait_ticks(OS);
        end
    endtask

    task automatic end_break(input int hold);
        wait_ticks(hold);
        chk("break_busy", bus.busy, 1);
        bus.rx = 1'b1;
        wait_ticks(1);
        chk("break_exit_busy", bus.busy, 0);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog cycles=80000 still running");
        $fatal(1);
    end

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_busy", bus.busy, 0);
`ifdef UART_RX_PARITY_EN
        chk("rst_parity_err", bus.parity_err, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        wait_ticks(3);

        send_frame(8'hA5, ^8'hA5, 1'b1);
        chk("idle_busy_a5", bus.busy, 0);

        // false start: low for 4 ticks only
        bus.rx = 1'b0;
        wait_ticks(1);
        chk("fs_busy_rise", bus.busy, 1);
        wait_ticks(3);
        bus.rx = 1'b1;
        wait_ticks(4);
        chk("fs_busy_tick7", bus.busy, 1);
        wait_ticks(1);
        chk("fs_busy_tick8", bus.busy, 0);
        wait_ticks(2);

        send_frame(8'h3C, ^8'h3C, 1'b0);
        end_break(5);

        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        chk("idle_busy_b2b", bus.busy, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1);
        chk("idle_busy_par", bus.busy, 0);
`endif

        // reset in the middle of a frame
        bus.rx = 1'b0;
        wait_ticks(61);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_rx_data", bus.rx_data, 0);
        chk("mid_rst_rx_valid", bus.rx_valid, 0);
        chk("mid_rst_frame_err", bus.frame_err, 0);
        chk("mid_rst_busy", bus.busy, 0);
        bus.rx = 1'b1;
        last_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(2);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        chk("idle_busy_5a", bus.busy, 0);

        for (int k = 0; k < 10; k++) begin
            logic [DB-1:0] d;
            logic          stop;
            logic          par;
            d    = DB'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = ^d;
            if ($urandom_range(0, 3) == 0) par = ~par;
            send_frame(d, par, stop);
            if (!stop) end_break($urandom_range(0, 6));
            else if ($urandom_range(0, 1) == 1) wait_ticks($urandom_range(1, 7));
        end

        wait_ticks(4);
        chk("all_pulses_seen", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
